// File: rtl/lif_tdm_array.sv
// lif_tdm_array: N leaky integrate-and-fire neurons sharing one update
// datapath. A round-robin scheduler visits one neuron per enabled cycle;
// membrane values live in a register file and all outputs are registered.
// Optional feature macro: LIF_REFRACTORY_EN (per-neuron refractory counters).
module lif_tdm_array #(
    parameter int WIDTH        = 8,
    parameter int N_NEURONS    = 4,
    parameter int DECAY_SHIFT  = 1,
    parameter int THRESH_RESET = 127,
    parameter int REFRAC       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [WIDTH-1:0]             current,
    input  logic                         thresh_we,
    input  logic [WIDTH-1:0]             thresh_in,
    output logic [$clog2(N_NEURONS)-1:0] idx,
    output logic                         spike,
    output logic [$clog2(N_NEURONS)-1:0] spike_idx,
    output logic [WIDTH-1:0]             state_out,
    output logic [N_NEURONS-1:0]         spike_vec,
    output logic                         sweep_done
);
    localparam int IDXW = $clog2(N_NEURONS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);

    logic [WIDTH-1:0]     r_state [N_NEURONS];
    logic [WIDTH-1:0]     r_thresh;
    logic [IDXW-1:0]      r_idx;
    logic [IDXW-1:0]      r_spikeIdx;
    logic                 r_spike;
    logic                 r_sweepDone;
    logic [WIDTH-1:0]     r_stateOut;
    logic [N_NEURONS-1:0] r_acc;
    logic [N_NEURONS-1:0] r_spikeVec;

    logic [WIDTH-1:0]     w_v;
    logic [WIDTH-1:0]     w_leak;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_newState;
    logic                 w_refracActive;
    logic                 w_fire;
    logic [N_NEURONS-1:0] w_fireMask;

    // Out-of-range refractory or leak settings elaborate this marker scope,
    // which makes a bad parameterisation easy to find in the hierarchy.
    if (REFRAC < 0 || REFRAC > 15 || DECAY_SHIFT >= WIDTH) begin : g_illegalConfig
    end

`ifdef LIF_REFRACTORY_EN
    logic [3:0] r_refrac [N_NEURONS];
    assign w_refracActive = (r_refrac[r_idx] != 4'd0);
`else
    assign w_refracActive = 1'b0;
`endif

    assign w_v        = r_state[r_idx];
    assign w_leak     = w_v >> DECAY_SHIFT;
    assign w_sum      = {1'b0, current} + {1'b0, w_leak};
    assign w_fire     = !w_refracActive && (w_v >= r_thresh);
    assign w_fireMask = {{(N_NEURONS-1){1'b0}}, w_fire} << r_idx;

    // New membrane value: cleared on refractory or firing visits, otherwise
    // the leaked state plus input current, clamped at the all-ones maximum.
    always_comb begin
        w_newState = w_sum[WIDTH-1:0];
        if (w_refracActive || w_fire) begin
            w_newState = '0;
        end else if (w_sum[WIDTH]) begin
            w_newState = '1;
        end
    end

    // Threshold register loads whenever written, regardless of the scheduler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thresh <= WIDTH'(THRESH_RESET);
        end else if (thresh_we) begin
            r_thresh <= thresh_in;
        end
    end

    // Per-neuron membrane (and refractory) storage, written for the visited neuron.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_state[i] <= '0;
`ifdef LIF_REFRACTORY_EN
                r_refrac[i] <= 4'd0;
`endif
            end
        end else if (en) begin
            r_state[r_idx] <= w_newState;
`ifdef LIF_REFRACTORY_EN
            if (w_refracActive) begin
                r_refrac[r_idx] <= r_refrac[r_idx] - 4'd1;
            end else if (w_fire) begin
                r_refrac[r_idx] <= 4'(REFRAC);
            end
`endif
        end
    end

    // Scheduler, visit outputs and sweep accumulator; pulses drop when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_spike     <= 1'b0;
            r_spikeIdx  <= '0;
            r_stateOut  <= '0;
            r_acc       <= '0;
            r_spikeVec  <= '0;
            r_sweepDone <= 1'b0;
        end else if (en) begin
            r_spike    <= w_fire;
            r_spikeIdx <= r_idx;
            r_stateOut <= w_newState;
            if (r_idx == LAST_IDX) begin
                r_idx       <= '0;
                r_spikeVec  <= r_acc | w_fireMask;
                r_acc       <= '0;
                r_sweepDone <= 1'b1;
            end else begin
                r_idx       <= r_idx + 1'b1;
                r_acc       <= r_acc | w_fireMask;
                r_sweepDone <= 1'b0;
            end
        end else begin
            r_spike     <= 1'b0;
            r_sweepDone <= 1'b0;
        end
    end

    assign idx        = r_idx;
    assign spike      = r_spike;
    assign spike_idx  = r_spikeIdx;
    assign state_out  = r_stateOut;
    assign spike_vec  = r_spikeVec;
    assign sweep_done = r_sweepDone;

endmodule

// File: tb/tb_lif_tdm_array.sv
// tb_lif_tdm_array: directed scenarios plus randomized traffic for
// lif_tdm_array, compared against a behavioural neuron-array model.
// Honours LIF_REFRACTORY_EN in the same way as the design.
module tb_lif_tdm_array;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int DS = 1;
    localparam int TR = 127;
    localparam int RF = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] current;
    logic         thresh_we;
    logic [W-1:0] thresh_in;
    logic [1:0]   idx;
    logic         spike;
    logic [1:0]   spike_idx;
    logic [W-1:0] state_out;
    logic [N-1:0] spike_vec;
    logic         sweep_done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain integers per neuron plus expected outputs.
    int mState [N];
    int mRefrac [N];
    int mT;
    int mIdx;
    int mAcc;
    int eSpike, eSpikeIdx, eStateOut, eSpikeVec, eSweepDone;

    lif_tdm_array #(
        .WIDTH(W), .N_NEURONS(N), .DECAY_SHIFT(DS), .THRESH_RESET(TR), .REFRAC(RF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .current(current),
        .thresh_we(thresh_we), .thresh_in(thresh_in), .idx(idx),
        .spike(spike), .spike_idx(spike_idx), .state_out(state_out),
        .spike_vec(spike_vec), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".idx"},        32'(idx),        32'(mIdx));
        checkValue({tag, ".spike"},      32'(spike),      32'(eSpike));
        checkValue({tag, ".spike_idx"},  32'(spike_idx),  32'(eSpikeIdx));
        checkValue({tag, ".state_out"},  32'(state_out),  32'(eStateOut));
        checkValue({tag, ".spike_vec"},  32'(spike_vec),  32'(eSpikeVec));
        checkValue({tag, ".sweep_done"}, 32'(sweep_done), 32'(eSweepDone));
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mState[i]  = 0;
            mRefrac[i] = 0;
        end
        mT = TR; mIdx = 0; mAcc = 0;
        eSpike = 0; eSpikeIdx = 0; eStateOut = 0; eSpikeVec = 0; eSweepDone = 0;
    endtask

    task automatic modelEdge(input int e, input int cur, input int we, input int tin);
        int v;
        int s;
        int f;
        eSpike = 0;
        eSweepDone = 0;
        if (e != 0) begin
            v = mState[mIdx];
            f = 0;
            if (mRefrac[mIdx] > 0) begin
                mState[mIdx] = 0;
                mRefrac[mIdx] = mRefrac[mIdx] - 1;
            end else if (v >= mT) begin
                f = 1;
                mState[mIdx] = 0;
`ifdef LIF_REFRACTORY_EN
                mRefrac[mIdx] = RF;
`endif
            end else begin
                s = cur + v / (1 << DS);
                mState[mIdx] = (s > MAXV) ? MAXV : s;
            end
            eSpike = f;
            eSpikeIdx = mIdx;
            eStateOut = mState[mIdx];
            if (f != 0) mAcc = mAcc | (1 << mIdx);
            if (mIdx == N - 1) begin
                eSpikeVec = mAcc;
                mAcc = 0;
                eSweepDone = 1;
                mIdx = 0;
            end else begin
                mIdx = mIdx + 1;
            end
        end
        if (we != 0) mT = tin;
    endtask

    // Drives one cycle of inputs, advances the model on the edge, checks after it.
    task automatic applyStimulus(input int e, input int cur, input int we, input int tin, input string tag);
        en = 1'(e);
        current = W'(cur);
        thresh_we = 1'(we);
        thresh_in = W'(tin);
        @(posedge clk);
        modelEdge(e, cur, we, tin);
        #1;
        checkOutput(tag);
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear at once.
    task automatic asyncReset();
        en = 1'b0;
        thresh_we = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n0, n1, doneCount;
        int tabState [6];
        int tabSpike [6];
        rst_n = 1'b0; en = 1'b0; current = '0; thresh_we = 1'b0; thresh_in = '0;
        modelReset();
        #12;
        checkOutput("por");
        rst_n = 1'b1;

        // Fire and refractory: neuron 0 fed 100, others 0.
`ifdef LIF_REFRACTORY_EN
        tabState = '{100, 150, 0, 0, 0, 100};
        tabSpike = '{0, 0, 1, 0, 0, 0};
`else
        tabState = '{100, 150, 0, 100, 150, 0};
        tabSpike = '{0, 0, 1, 0, 0, 1};
`endif
        n0 = 0;
        for (int k = 0; k < 24; k++) begin
            if (mIdx == 0) begin
                applyStimulus(1, 100, 0, 0, "fire");
                checkValue("fire.n0_state", 32'(state_out), 32'(tabState[n0]));
                checkValue("fire.n0_spike", 32'(spike), 32'(tabSpike[n0]));
                checkValue("fire.n0_spike_idx", 32'(spike_idx), 32'd0);
                n0++;
            end else begin
                applyStimulus(1, 0, 0, 0, "fire");
            end
        end

        // Enable hold at idx 2.
        applyStimulus(1, 30, 0, 0, "hold_pre");
        applyStimulus(1, 40, 0, 0, "hold_pre");
        checkValue("hold.idx_at_2", 32'(idx), 32'd2);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, $urandom_range(0, 255), 0, 0, "hold");
            checkValue("hold.idx_held", 32'(idx), 32'd2);
            checkValue("hold.spike_low", 32'(spike), 32'd0);
        end
        applyStimulus(1, 10, 0, 0, "hold_resume");
        checkValue("hold.resume_idx", 32'(spike_idx), 32'd2);

        // Saturation with threshold raised to 255.
        asyncReset();
        applyStimulus(0, 0, 1, 255, "sat_wr");
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            if (mIdx == 1) begin
                applyStimulus(1, 200, 0, 0, "sat");
                checkValue("sat.n1_state", 32'(state_out), (n1 == 0) ? 32'd200 : 32'd255);
                checkValue("sat.n1_spike", 32'(spike), 32'd0);
                n1++;
            end else begin
                applyStimulus(1, 0, 0, 0, "sat");
            end
        end

        // Sweep vector: neurons 0 and 3 driven high, 1 and 2 idle.
        asyncReset();
        doneCount = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1, (mIdx == 0 || mIdx == 3) ? 200 : 0, 0, 0, "sweep");
            if (k >= 4 && k <= 7 && sweep_done === 1'b1) doneCount++;
            if (k == 3) checkValue("sweep.first_vec", 32'(spike_vec), 32'd0);
            if (k == 7) begin
                checkValue("sweep.second_vec", 32'(spike_vec), 32'b1001);
                checkValue("sweep.second_done", 32'(sweep_done), 32'd1);
            end
        end
        checkValue("sweep.done_pulses", 32'(doneCount), 32'd1);

        // Threshold write racing a visit of neuron 0 holding 100.
        asyncReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, (mIdx == 0) ? 100 : 0, 0, 0, "race_pre");
        end
        applyStimulus(1, 0, 1, 50, "race");
        checkValue("race.no_spike", 32'(spike), 32'd0);
        checkValue("race.state", 32'(state_out), 32'd50);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 0, 0, "race_post");
        end
        applyStimulus(1, 0, 0, 0, "race_fire");
        checkValue("race.fire_spike", 32'(spike), 32'd1);
        checkValue("race.fire_idx", 32'(spike_idx), 32'd0);

        // Randomized traffic with occasional threshold writes and resets.
        asyncReset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                asyncReset();
            end else begin
                applyStimulus(($urandom_range(0, 3) != 0) ? 1 : 0,
                              int'($urandom_range(0, 255)),
                              ($urandom_range(0, 15) == 0) ? 1 : 0,
                              int'($urandom_range(20, 255)),
                              "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
